// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter that owns the 4:1 mux select.
// Sources a..d map to indices 0..3, matching req/gnt bit order.
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SRC_A = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B = 2'd1;
    localparam logic [SEL_W-1:0] SRC_C = 2'd2;
    localparam logic [SEL_W-1:0] SRC_D = 2'd3;

    // Pointer starts at the last source so source a wins the first arbitration.
    localparam logic [SEL_W-1:0] PTR_RESET = SRC_D;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set req bit scanning upward
// from base+1 with wrap-around, so base itself has the lowest priority.
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned infers a latch.
        any    = 1'b0;
        idx    = base;
        onehot = '0;
        cand   = base;
        // Scan from lowest to highest priority so the highest-priority hit is written last.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = base + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot = N_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant and the 4:1 mux select {s1,s0}.
// Ownership is capped at MAX_HOLD consecutive cycles (0 = unlimited).
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic [3:0]       hold_cnt
);

    localparam int         LIMIT_I    = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [3:0] HOLD_LIMIT = 4'(LIMIT_I);
    localparam logic [3:0] HOLD_SAT   = 4'd15;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [3:0]       hold_q, hold_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             at_limit;

    // The pointer always equals the current owner while BUSY, so one picker based
    // on it covers both the idle grant and the re-arbitration on release or limit.
    rr_pick u_pick (
        .req    (req),
        .base   (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;

        if (state_q == ST_IDLE || !req[sel_q] || at_limit) begin
            if (pick_any) begin
                state_d = ST_BUSY;
                ptr_d   = pick_idx;
                sel_d   = pick_idx;
                gnt_d   = pick_onehot;
                hold_d  = '0;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RESET;
            sel_q   <= SRC_A;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = |gnt_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand sequences for
// rotation and sole-requester wrap, then random traffic against a behavioural model.
module tb_mux_rr_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: owner = -1 when nobody holds the mux.
    int m_owner = -1;
    int m_ptr   = 3;
    int m_sel   = 0;
    int m_hold  = 0;

    mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] hold;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int rr_winner(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] q);
        int w;
        if (r) begin
            m_owner = -1; m_ptr = 3; m_sel = 0; m_hold = 0;
        end else if (m_owner >= 0 && q[m_owner] && !(MH != 0 && m_hold == MH - 1)) begin
            m_hold = (m_hold < 15) ? m_hold + 1 : 15;
        end else begin
            w = rr_winner(q, m_ptr);
            m_hold = 0;
            m_owner = w;
            if (w >= 0) begin
                m_ptr = w;
                m_sel = w;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
    endtask

    task automatic check_model(input string tag);
        int exp_gnt;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        check({tag, ".gnt"}, int'(gnt), exp_gnt);
        check({tag, ".sel"}, int'(sel), m_sel);
        check({tag, ".hold"}, int'(hold_cnt), m_hold);
        check({tag, ".valid"}, int'(gnt_valid), int'(exp_gnt != 0));
        check({tag, ".onehot"}, int'($countones(gnt) <= 1), 1);
    endtask

    vec_t vecs[$];
    logic [3:0] prev_gnt;
    int run_len;
    logic [3:0] rq;

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requesting; idle grant; drop; owner 1 then release to {3,0}; reset mid-grant.
        vecs.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 4'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 4'd0});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 4'd0});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd2, 4'd0});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 4'd0});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 4'd1});
        vecs.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 4'd0});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd3, 4'd0});
        vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 4'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 4'd0});
        vecs.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 4'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d.gnt", i), int'(gnt), int'(vecs[i].gnt));
            check($sformatf("vec%0d.sel", i), int'(sel), int'(vecs[i].sel));
            check($sformatf("vec%0d.hold", i), int'(hold_cnt), int'(vecs[i].hold));
            check($sformatf("vec%0d.valid", i), int'(gnt_valid), int'(vecs[i].gnt != 0));
        end

        // Full contention: owners rotate 0,1,2,3,0 with exactly MH cycles each, no gap.
        step(1'b1, 4'b1111);
        prev_gnt = 4'b0000;
        run_len = 0;
        for (int c = 0; c < 5 * MH; c++) begin
            step(1'b0, 4'b1111);
            check_model("rot");
            check("rot.nogap", int'(gnt != 0), 1);
            check("rot.owner", int'(gnt), 1 << ((c / MH) % 4));
            if (c > 0 && gnt != prev_gnt) begin
                check("rot.runlen", run_len, MH);
                run_len = 0;
            end
            run_len++;
            prev_gnt = gnt;
        end

        // Sole requester: re-granted at the limit, hold_cnt wraps 7->0.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0100);
            check("sole.gnt", int'(gnt), 4);
            check("sole.hold", int'(hold_cnt), c % MH);
            check("sole.sel", int'(sel), 2);
        end

        // Random traffic with sticky requests and rare resets.
        step(1'b1, 4'b0000);
        rq = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 49) == 0, rq);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
